// File: rtl/conv_window_gen_pkg.sv
// Shared constants and helpers for the sliding-window generator and its consumers.
// The tap packing offset is the contract with the convolution element.
package conv_window_gen_pkg;

    // Counter width that never collapses to zero bits for tiny frames.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    function automatic bit kernel_legal(input int k);
        return (k == 1) || (k == 3) || (k == 5) || (k == 7);
    endfunction

    // Bit offset of tap (r,c) of channel i inside the packed window.
    function automatic int tap_ofs(input int i, input int r, input int c,
                                   input int k, input int n);
        return i * k * k * n + (r * k + c) * n;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buf.sv
// One raster line of pixels held in a circular RAM indexed by column.
// Read of the previous-row entry is combinational; the new pixel replaces it on the same edge.
module conv_window_gen_line_buf
    import conv_window_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 28,
    parameter int AW    = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign dout_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= din_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Builds KERNEL x KERNEL valid-mode windows from a raster pixel stream using a chain of
// line buffers and a shift-register window; each complete window is strobed out once.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int CL_IN  = 4,
    parameter int KERNEL = 7,
    parameter int N      = 2,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CL_IN*N-1:0]                 pix_in,
    input  logic                               en_in,
    input  logic                               sof_in,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0]   data2conv,
    output logic                               en_out,
    output logic                               frame_done,
    output logic                               sof_err
);

    localparam int PIX_W = CL_IN * N;
    localparam int OUT_W = CL_IN * KERNEL * KERNEL * N;
    localparam int CW    = clog2_min1(IMG_W);
    localparam int RW    = clog2_min1(IMG_H);

    if (!kernel_legal(KERNEL) || IMG_W < KERNEL || IMG_H < KERNEL) begin : g_bad_cfg
        $error("conv_window_gen: illegal KERNEL/IMG_W/IMG_H combination");
    end

    logic [CW-1:0]    col_q, col_d, col_eff;
    logic [RW-1:0]    row_q, row_d, row_eff;
    logic             sof_hit, last_col, last_row, emit;
    logic             en_out_q, frame_done_q, sof_err_q, sof_err_d;
    logic [OUT_W-1:0] data_q, packed_d;

    // lb_chain[d] is the pixel at the current column from d rows ago.
    logic [PIX_W-1:0] lb_chain [KERNEL];
    logic [PIX_W-1:0] win_q [KERNEL][KERNEL];
    logic [PIX_W-1:0] win_d [KERNEL][KERNEL];

    // A start-of-frame pixel is treated as (0,0) regardless of where the counters stood.
    always_comb begin
        sof_hit  = en_in && sof_in;
        col_eff  = sof_hit ? '0 : col_q;
        row_eff  = sof_hit ? '0 : row_q;
        last_col = (col_eff == CW'(IMG_W - 1));
        last_row = (row_eff == RW'(IMG_H - 1));
        emit     = en_in && (int'(row_eff) >= KERNEL - 1) && (int'(col_eff) >= KERNEL - 1);
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        sof_err_d = sof_err_q;
        if (en_in) begin
            col_d = last_col ? '0 : col_eff + CW'(1);
            row_d = row_eff;
            if (last_col) begin
                row_d = last_row ? '0 : row_eff + RW'(1);
            end
            if (sof_hit && (col_q != '0 || row_q != '0)) begin
                sof_err_d = 1'b1;
            end
        end
    end

    assign lb_chain[0] = pix_in;

    for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
        conv_window_gen_line_buf #(
            .WIDTH (PIX_W),
            .DEPTH (IMG_W),
            .AW    (CW)
        ) u_lb (
            .clk     (clk),
            .wr_en_i (en_in),
            .addr_i  (col_eff),
            .din_i   (lb_chain[j]),
            .dout_o  (lb_chain[j+1])
        );
    end

    // Window row r holds the row KERNEL-1-r lines back; columns shift left, newest enters at K-1.
    always_comb begin
        win_d = win_q;
        if (en_in) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KERNEL-1] = lb_chain[KERNEL-1-r];
            end
        end
    end

    always_comb begin
        packed_d = '0;
        for (int i = 0; i < CL_IN; i++) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    packed_d[tap_ofs(i, r, c, KERNEL, N) +: N] = win_d[r][c][i*N +: N];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            en_out_q     <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            data_q       <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            en_out_q     <= emit;
            frame_done_q <= en_in && last_col && last_row;
            sof_err_q    <= sof_err_d;
            if (emit) begin
                data_q <= packed_d;
            end
        end
    end

    assign data2conv  = data_q;
    assign en_out     = en_out_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench: a 3x3 two-channel instance on a 4x4 frame and a 1x1 instance on a 3x3 frame.
module tb_conv_window_gen;

    localparam int OW_A = 2 * 3 * 3 * 8;

    typedef struct {
        logic [OW_A-1:0] d;
        int              cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      pix_a = '0;
    logic             en_a = 1'b0, sof_a = 1'b0;
    logic [OW_A-1:0]  d2c_a;
    logic             eno_a, fd_a, serr_a;
    logic [7:0]       pix_b = '0;
    logic             en_b = 1'b0, sof_b = 1'b0;
    logic [7:0]       d2c_b;
    logic             eno_b, fd_b, serr_b;

    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   qfa[$];
    int   qfb[$];

    conv_window_gen #(.CL_IN(2), .KERNEL(3), .N(8), .IMG_W(4), .IMG_H(4)) u_a (
        .clk(clk), .rst(rst), .pix_in(pix_a), .en_in(en_a), .sof_in(sof_a),
        .data2conv(d2c_a), .en_out(eno_a), .frame_done(fd_a), .sof_err(serr_a)
    );

    conv_window_gen #(.CL_IN(1), .KERNEL(1), .N(8), .IMG_W(3), .IMG_H(3)) u_b (
        .clk(clk), .rst(rst), .pix_in(pix_b), .en_in(en_b), .sof_in(sof_b),
        .data2conv(d2c_b), .en_out(eno_b), .frame_done(fd_b), .sof_err(serr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [OW_A-1:0] act, input logic [OW_A-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Window whose bottom-right pixel is (r,c) of a frame with pixel = base + row*4 + col, ch1 = ch0 + 16.
    function automatic logic [OW_A-1:0] exp_win(input int base, input int r, input int c);
        logic [OW_A-1:0] w;
        int v;
        w = '0;
        for (int i = 0; i < 2; i++)
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++) begin
                    v = base + (r - 2 + rr) * 4 + (c - 2 + cc) + 16 * i;
                    w[i*72 + (rr*3+cc)*8 +: 8] = 8'(v);
                end
        return w;
    endfunction

    // Sends the first npix pixels of a frame (sof on the first); gap inserts an idle cycle before each.
    task automatic send_a(input int base, input bit gap, input int npix);
        exp_t e;
        int r, c, v;
        for (int k = 0; k < npix; k++) begin
            r = k / 4;
            c = k % 4;
            v = base + k;
            if (gap && k != 0) begin
                @(posedge clk); #1;
                en_a = 1'b0; sof_a = 1'b0;
            end
            @(posedge clk); #1;
            pix_a = {8'(v + 16), 8'(v)};
            en_a  = 1'b1;
            sof_a = (k == 0);
            if (r >= 2 && c >= 2) begin
                e.d = exp_win(base, r, c);
                e.cyc = cyc + 1;
                qa.push_back(e);
            end
            if (k == 15) qfa.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        en_a = 1'b0; sof_a = 1'b0;
    endtask

    task automatic send_b();
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            pix_b = 8'(7 * k + 3);
            en_b  = 1'b1;
            sof_b = (k == 0);
            e.d   = OW_A'(8'(7 * k + 3));
            e.cyc = cyc + 1;
            qb.push_back(e);
            if (k == 8) qfb.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        en_b = 1'b0; sof_b = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected entry, both in data and in cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (eno_a) begin
                if (qa.size() == 0) chk("a_unexpected_en_out", 1, 0);
                else begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("a_window", d2c_a, e.d);
                    chk("a_window_cycle", OW_A'(cyc), OW_A'(e.cyc));
                end
            end
            if (fd_a) begin
                if (qfa.size() == 0) chk("a_unexpected_frame_done", 1, 0);
                else chk("a_frame_done_cycle", OW_A'(cyc), OW_A'(qfa.pop_front()));
            end
            if (eno_b) begin
                if (qb.size() == 0) chk("b_unexpected_en_out", 1, 0);
                else begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("b_window", OW_A'(d2c_b), e.d);
                    chk("b_window_cycle", OW_A'(cyc), OW_A'(e.cyc));
                end
            end
            if (fd_b) begin
                if (qfb.size() == 0) chk("b_unexpected_frame_done", 1, 0);
                else chk("b_frame_done_cycle", OW_A'(cyc), OW_A'(qfb.pop_front()));
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_a_en_out"}, OW_A'(eno_a), 0);
        chk({tag, "_a_frame_done"}, OW_A'(fd_a), 0);
        chk({tag, "_a_sof_err"}, OW_A'(serr_a), 0);
        chk({tag, "_a_data2conv"}, d2c_a, 0);
        chk({tag, "_b_en_out"}, OW_A'(eno_b), 0);
        chk({tag, "_b_data2conv"}, OW_A'(d2c_b), 0);
    endtask

    task automatic drain(input string tag);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_windows_outstanding"}, OW_A'(qa.size() + qb.size()), 0);
        chk({tag, "_frame_done_outstanding"}, OW_A'(qfa.size() + qfb.size()), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Continuous frame: windows at pixels 10,11,14,15.
        send_a(0, 1'b0, 16);
        drain("continuous");
        chk("continuous_sof_err", OW_A'(serr_a), 0);

        // Same geometry with idle cycles between pixels.
        send_a(40, 1'b1, 16);
        drain("gapped");
        chk("gapped_sof_err", OW_A'(serr_a), 0);

        // Abort after six pixels (counters at row 1, col 2) with a fresh sof.
        send_a(200, 1'b0, 6);
        send_a(100, 1'b0, 16);
        drain("resync");
        chk("resync_sof_err", OW_A'(serr_a), 1);

        // Reset in the middle of a frame, then a clean frame.
        send_a(0, 1'b0, 10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("midreset");
        rst = 1'b0;
        send_a(60, 1'b0, 16);
        drain("after_reset");

        // 1x1 kernel: every pixel comes straight back.
        send_b();
        drain("k1");
        chk("k1_sof_err", OW_A'(serr_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
